mem_trace_capture: RTL and testbench

//  Bus tap between the CPU memory interface and the debug monitor / UART dump path.

---
 rtl/dbg_trace_pkg.sv | 24 ++
 rtl/trace_fifo.sv | 52 +++++
 rtl/mem_trace_capture.sv | 112 +++++++++++
 tb/tb_mem_trace_capture.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dbg_trace_pkg.sv
// Shared types for the memory trace tap: FSM encodings, the trace record layout
// and the default address filter window.
package dbg_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  // 113-bit record as it sits in the capture FIFO
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] address;
    logic [31:0] data;
    logic        write;
    logic [15:0] seq;
  } trace_rec_t;

  localparam logic [31:0] DEF_ADDR_LO = 32'h8000_0000;
  localparam logic [31:0] DEF_ADDR_HI = 32'h8001_0000;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO: a push into an empty FIFO is visible at the head one cycle later.
// Push is refused when full unless a pop happens in the same cycle; flush overrides push and pop.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer bit separates full from empty when the indices coincide
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/mem_trace_capture.sv
// Memory bus tap: records qualifying beats from PC trigger until the beat budget is met; record out 1 cycle after the beat.
// Records drain on valid/ready; beats arriving while the FIFO is full are dropped and counted.
module mem_trace_capture
  import dbg_trace_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] ADDR_LO = DEF_ADDR_LO,
  parameter logic [31:0] ADDR_HI = DEF_ADDR_HI
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [31:0]               i_PC,
  input  logic [31:0]               i_mem_address,
  input  logic [31:0]               i_mem_data,
  input  logic                      i_mem_DV,
  input  logic                      i_mem_write,
  input  logic                      i_arm,
  input  logic [31:0]               i_trigger_PC,
  input  logic [15:0]               i_capture_len,
  input  logic                      i_filter_en,
  output logic                      o_rec_valid,
  input  logic                      i_rec_ready,
  output logic [31:0]               o_rec_address,
  output logic [31:0]               o_rec_data,
  output logic                      o_rec_write,
  output logic [31:0]               o_rec_PC,
  output logic [15:0]               o_rec_seq,
  output logic [1:0]                o_state,
  output logic [15:0]               o_overflow_count,
  output logic [$clog2(DEPTH):0]    o_fifo_level
);

  trace_state_t state, state_nxt;
  logic [15:0]  seq_q, beat_q, ovf_q;
  logic         in_win, qual, trig_hit, rec_beat, len_hit;
  logic         fifo_empty, fifo_full, rec_pop, rec_push;
  trace_rec_t   push_rec, head_rec, out_rec;

  assign in_win   = (i_mem_address >= ADDR_LO) && (i_mem_address < ADDR_HI);
  assign qual     = i_mem_DV && (!i_filter_en || in_win);
  assign trig_hit = (state == ST_ARMED) && (i_PC == i_trigger_PC);
  assign rec_beat = !i_arm && qual && ((state == ST_CAPTURE) || trig_hit);
  assign rec_pop  = !fifo_empty && i_rec_ready;
  assign rec_push = rec_beat && (!fifo_full || rec_pop);
  assign len_hit  = (i_capture_len != 16'd0) && ((beat_q + 16'd1) == i_capture_len);

  assign push_rec = '{pc: i_PC, address: i_mem_address, data: i_mem_data,
                      write: i_mem_write, seq: seq_q};

  trace_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(trace_rec_t))
  ) u_fifo (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .flush    (i_arm),
    .push     (rec_push),
    .push_dat (push_rec),
    .pop      (rec_pop),
    .pop_dat  (head_rec),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (o_fifo_level)
  );

  always_comb begin
    state_nxt = state;
    if (i_arm) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED:   if (trig_hit) state_nxt = (rec_beat && len_hit) ? ST_DONE : ST_CAPTURE;
        ST_CAPTURE: if (rec_beat && len_hit) state_nxt = ST_DONE;
        default:    state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Dropped beats still consume a sequence number so gaps show up downstream
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seq_q  <= '0;
      beat_q <= '0;
      ovf_q  <= '0;
    end else if (i_arm) begin
      seq_q  <= '0;
      beat_q <= '0;
      ovf_q  <= '0;
    end else if (rec_beat) begin
      seq_q  <= seq_q + 16'd1;
      beat_q <= beat_q + 16'd1;
      if (!rec_push && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  // Head of an empty FIFO is stale storage; present zeros instead
  assign out_rec          = fifo_empty ? '0 : head_rec;
  assign o_rec_valid      = !fifo_empty;
  assign o_rec_address    = out_rec.address;
  assign o_rec_data       = out_rec.data;
  assign o_rec_write      = out_rec.write;
  assign o_rec_PC         = out_rec.pc;
  assign o_rec_seq        = out_rec.seq;
  assign o_state          = state;
  assign o_overflow_count = ovf_q;

endmodule

// File: tb/tb_mem_trace_capture.sv
// Scoreboard bench for mem_trace_capture: expected records queued at stimulus, checked at drain.
module tb_mem_trace_capture;
  import dbg_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] TRIG = 32'h8000_0100;

  logic          clk, rst_n;
  logic [31:0]   i_PC, i_mem_address, i_mem_data, i_trigger_PC;
  logic          i_mem_DV, i_mem_write, i_arm, i_filter_en, i_rec_ready;
  logic [15:0]   i_capture_len;
  logic          rec_valid, rec_write;
  logic [31:0]   rec_address, rec_data, rec_pc;
  logic [15:0]   rec_seq, ovf;
  logic [1:0]    state;
  logic [LW-1:0] fifo_level;

  int         n_checks = 0;
  int         n_errors = 0;
  trace_rec_t exp_q[$];
  trace_rec_t mon_exp;
  trace_rec_t mon_obs;

  mem_trace_capture #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_PC(i_PC), .i_mem_address(i_mem_address),
    .i_mem_data(i_mem_data), .i_mem_DV(i_mem_DV), .i_mem_write(i_mem_write),
    .i_arm(i_arm), .i_trigger_PC(i_trigger_PC), .i_capture_len(i_capture_len),
    .i_filter_en(i_filter_en), .o_rec_valid(rec_valid), .i_rec_ready(i_rec_ready),
    .o_rec_address(rec_address), .o_rec_data(rec_data), .o_rec_write(rec_write),
    .o_rec_PC(rec_pc), .o_rec_seq(rec_seq), .o_state(state),
    .o_overflow_count(ovf), .o_fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every accepted record is matched against the oldest expected one
  always @(negedge clk) begin
    if (rst_n && rec_valid && i_rec_ready) begin
      chk("sb_has_entry", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_obs = '{pc: rec_pc, address: rec_address, data: rec_data,
                    write: rec_write, seq: rec_seq};
        chk("rec_seq", rec_seq, mon_exp.seq);
        chk("rec_body", mon_obs, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    i_PC  = 32'h0;
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
    exp_q.delete();
  endtask

  task automatic beat(input logic [31:0] pc, input logic [31:0] addr, input logic wr,
                      input bit rec, input logic [15:0] seq);
    i_PC = pc; i_mem_address = addr; i_mem_data = ~addr; i_mem_write = wr; i_mem_DV = 1'b1;
    if (rec) exp_q.push_back('{pc: pc, address: addr, data: ~addr, write: wr, seq: seq});
    tick();
    i_mem_DV = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    i_rec_ready = 1'b1;
    for (int i = 0; i < max_cyc && rec_valid; i++) tick();
    i_rec_ready = 1'b0;
    chk("drain_done", rec_valid, 1'b0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_PC = '0; i_mem_address = '0; i_mem_data = '0; i_mem_DV = 1'b0;
    i_mem_write = 1'b0; i_arm = 1'b0; i_trigger_PC = TRIG; i_capture_len = '0;
    i_filter_en = 1'b0; i_rec_ready = 1'b0;
    #12;
    chk("rst_state", state, ST_IDLE);
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rec", {rec_pc, rec_address, rec_data, rec_write, rec_seq}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Length-limited capture triggered together with the first beat
    i_capture_len = 16'd3;
    arm();
    chk("t1_armed", state, ST_ARMED);
    beat(TRIG,          32'h8000_0000, 1'b1, 1, 16'd0);
    beat(32'h8000_0104, 32'h8000_0004, 1'b0, 1, 16'd1);
    beat(32'h8000_0108, 32'h8000_0008, 1'b1, 1, 16'd2);
    chk("t1_done", state, ST_DONE);
    beat(32'h8000_010C, 32'h8000_000C, 1'b0, 0, 16'd0);
    chk("t1_level", fifo_level, 3);
    drain(10);

    // Address window edges
    i_capture_len = 16'd0;
    i_filter_en   = 1'b1;
    arm();
    i_PC = TRIG;
    tick();
    chk("t2_capture", state, ST_CAPTURE);
    beat(32'h1000, 32'h7FFF_FFFC, 1'b0, 0, 16'd0);
    beat(32'h1004, 32'h8000_0000, 1'b1, 1, 16'd0);
    beat(32'h1008, 32'h8000_FFFC, 1'b0, 1, 16'd1);
    beat(32'h100C, 32'h8001_0000, 1'b1, 0, 16'd0);
    chk("t2_level", fifo_level, 2);
    drain(10);

    // Overflow: DEPTH stored, 3 dropped, then in-order drain
    i_filter_en = 1'b0;
    arm();
    i_PC = TRIG;
    tick();
    for (int i = 0; i < DEPTH + 3; i++)
      beat(32'h2000 + 32'(4 * i), 32'h8000_0000 + 32'(4 * i), i[0], i < DEPTH, 16'(i));
    chk("t3_level", fifo_level, DEPTH);
    chk("t3_ovf", ovf, 3);
    chk("t3_state", state, ST_CAPTURE);
    drain(DEPTH + 4);

    // Full FIFO: simultaneous pop lets the beat in; without a pop it is dropped
    arm();
    i_PC = TRIG;
    tick();
    for (int i = 0; i < DEPTH; i++)
      beat(32'h3000 + 32'(4 * i), 32'h8000_0100 + 32'(4 * i), 1'b1, 1, 16'(i));
    chk("t4_full", fifo_level, DEPTH);
    i_rec_ready = 1'b1;
    beat(32'h3100, 32'h8000_0200, 1'b0, 1, 16'(DEPTH));
    i_rec_ready = 1'b0;
    chk("t4_level_pp", fifo_level, DEPTH);
    chk("t4_ovf_pp", ovf, 0);
    beat(32'h3104, 32'h8000_0204, 1'b0, 0, 16'(DEPTH + 1));
    chk("t4_ovf_drop", ovf, 1);
    i_rec_ready = 1'b1;
    repeat (DEPTH - 5) tick();
    i_rec_ready = 1'b0;
    chk("t4_level5", fifo_level, 5);

    // Re-arm mid-capture discards records and counters
    arm();
    chk("t5_level", fifo_level, 0);
    chk("t5_valid", rec_valid, 1'b0);
    chk("t5_ovf", ovf, 0);
    chk("t5_state", state, ST_ARMED);
    beat(TRIG, 32'h8000_0040, 1'b0, 1, 16'd0);
    chk("t5_level1", fifo_level, 1);
    drain(4);

    // Asynchronous reset between clock edges
    arm();
    beat(TRIG,          32'h8000_0010, 1'b1, 1, 16'd0);
    beat(32'h8000_0104, 32'h8000_0014, 1'b1, 1, 16'd1);
    beat(32'h8000_0108, 32'h8000_0018, 1'b0, 1, 16'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_state", state, ST_IDLE);
    chk("t6_valid", rec_valid, 1'b0);
    chk("t6_level", fifo_level, 0);
    chk("t6_rec", {rec_pc, rec_address, rec_data, rec_write, rec_seq}, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;

    // IDLE ignores beats; arm outranks a trigger in the same cycle
    beat(TRIG, 32'h8000_0020, 1'b0, 0, 16'd0);
    chk("t7_idle_level", fifo_level, 0);
    chk("t7_idle_state", state, ST_IDLE);
    arm();
    i_PC = TRIG; i_mem_address = 32'h8000_0024; i_mem_DV = 1'b1; i_arm = 1'b1;
    tick();
    i_arm = 1'b0; i_mem_DV = 1'b0; i_PC = 32'h0;
    chk("t7_arm_state", state, ST_ARMED);
    chk("t7_arm_level", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
